ram_stream_reader: RTL and testbench

Read-side initiator for the team's multi-port RAM blocks (registered read, one cycle latency, no read enable). On a start command it walks a contiguous, wrapping address range on one RAM read port and delivers the words as a valid/ready stream, in address order. Backpressure is absorbed by an internal 4-entry FIFO with credit-based issue. HLS-generated datapaths use it to stream array contents out of a RAM bank.

---
 rtl/ram_stream_reader_if.sv | 24 ++
 rtl/ram_stream_reader.sv | 173 +++++++++++++++++
 tb/tb_ram_stream_reader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream produced by ram_stream_reader.
// The master drives valid/data/last; the slave answers with ready.
interface ram_stream_reader_if #(
    parameter int WIDTH = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams a wrapping address range of a registered-read RAM port as valid/ready words.
// A 4-entry FIFO plus credit-based issue absorbs backpressure without dropping reads.
module ram_stream_reader #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   raddr,
    input  logic [WIDTH-1:0]      rdata,
    ram_stream_reader_if.master   stream
);

    localparam int                FIFO_DEPTH = 4;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                           state_q, state_d;
    logic [ADDR_WIDTH:0]              addr_q, addr_d;
    logic [ADDR_WIDTH:0]              remaining_q, remaining_d;
    logic [ADDR_WIDTH:0]              raddr_q, raddr_d;
    logic                             issue_q, issue_d;
    logic                             issue_last_q, issue_last_d;
    logic                             pend_q, pend_d;
    logic                             pend_last_q, pend_last_d;
    logic                             done_q, done_d;
    logic [FIFO_DEPTH-1:0][WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic [FIFO_DEPTH-1:0]            fifo_last_q, fifo_last_d;
    logic [2:0]                       fifo_count_q, fifo_count_d;

    logic [ADDR_WIDTH:0] cur_addr;
    logic [ADDR_WIDTH:0] cur_rem;
    logic [2:0]          in_flight;
    logic                credit_ok;
    logic                do_issue;
    logic                pop;
    logic                push;
    logic [2:0]          count_after_pop;

    assign pop  = (fifo_count_q != 3'd0) && stream.out_ready;
    assign push = pend_q;

    // The first read issues on the same edge that accepts start, giving the
    // two-cycle start-to-first-word latency.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        raddr_d      = raddr_q;
        issue_d      = 1'b0;
        issue_last_d = 1'b0;
        pend_d       = issue_q;
        pend_last_d  = issue_last_q;
        done_d       = 1'b0;
        cur_addr     = addr_q;
        cur_rem      = remaining_q;
        do_issue     = 1'b0;
        in_flight    = fifo_count_q + {2'b00, issue_q} + {2'b00, pend_q};
        credit_ok    = in_flight < 3'(FIFO_DEPTH);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        cur_addr = base_addr;
                        cur_rem  = len;
                        do_issue = credit_ok;
                    end
                end
            end
            RUN: begin
                do_issue = credit_ok;
            end
            DRAIN: begin
                if (pop && fifo_last_q[0]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        addr_d      = cur_addr;
        remaining_d = cur_rem;

        if (do_issue) begin
            issue_d      = 1'b1;
            raddr_d      = cur_addr;
            addr_d       = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ONE;
            remaining_d  = cur_rem - ONE;
            issue_last_d = (cur_rem == ONE);
            if (cur_rem == ONE) begin
                state_d = DRAIN;
            end
        end
    end

    // Shift-down FIFO: entry 0 is always the head, so the stream outputs come
    // straight from flops.
    always_comb begin
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        count_after_pop = fifo_count_q - {2'b00, pop};

        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_data_d[i] = fifo_data_q[i+1];
                fifo_last_d[i] = fifo_last_q[i+1];
            end
            fifo_last_d[FIFO_DEPTH-1] = 1'b0;
        end

        if (push) begin
            fifo_data_d[count_after_pop[1:0]] = rdata;
            fifo_last_d[count_after_pop[1:0]] = pend_last_q;
        end

        fifo_count_d = count_after_pop + {2'b00, push};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            raddr_q      <= '0;
            issue_q      <= 1'b0;
            issue_last_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            done_q       <= 1'b0;
            fifo_data_q  <= '0;
            fifo_last_q  <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            raddr_q      <= raddr_d;
            issue_q      <= issue_d;
            issue_last_q <= issue_last_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            done_q       <= done_d;
            fifo_data_q  <= fifo_data_d;
            fifo_last_q  <= fifo_last_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign raddr            = raddr_q;
    assign stream.out_valid = (fifo_count_q != 3'd0);
    assign stream.out_data  = fifo_data_q[0];
    assign stream.out_last  = fifo_last_q[0] & (fifo_count_q != 3'd0);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a registered-read RAM model
// preloaded with data[i] = 0x100 + i.
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  base_addr;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [31:0] ram [16];

    int tests_run    = 0;
    int tests_failed = 0;

    ram_stream_reader_if #(.WIDTH(32)) s_if ();

    ram_stream_reader #(
        .WIDTH(32),
        .DEPTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .raddr     (raddr),
        .rdata     (rdata),
        .stream    (s_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= ram[raddr[3:0]];

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h100 + 32'(i);
    end

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        s_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        tests_run++;
        if (s_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", s_if.out_valid); end
        tests_run++;
        if (s_if.out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_last: got %b expected 0", s_if.out_last); end
        tests_run++;
        if (raddr !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_raddr: got %0d expected 0", raddr); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        base_addr = 5'd3;
        len = 5'd4;
        start = 1'b1;
        s_if.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
        tests_run++;
        if (raddr !== 5'd3) begin tests_failed++; $display("[TB] FAIL basic_raddr0: got %0d expected 3", raddr); end
        @(negedge clk);
        tests_run++;
        if (s_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_early_valid: got %b expected 0", s_if.out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (s_if.out_valid !== 1'b1 || s_if.out_data !== 32'h103 + 32'(i) || s_if.out_last !== (i == 3)) begin
                tests_failed++;
                $display("[TB] FAIL basic_word[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, s_if.out_valid, s_if.out_data, s_if.out_last, 32'h103 + 32'(i), (i == 3));
            end
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || s_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_done: got done=%b busy=%b valid=%b expected 1 0 0", done, busy, s_if.out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_wrap;
        int wrap_addr[5] = '{14, 15, 0, 1, 2};
        base_addr = 5'd14;
        len = 5'd5;
        start = 1'b1;
        s_if.out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c < 5) begin
                tests_run++;
                if (raddr !== 5'(wrap_addr[c])) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_raddr[%0d]: got %0d expected %0d", c, raddr, wrap_addr[c]);
                end
            end
            if (c >= 2) begin
                tests_run++;
                if (s_if.out_valid !== 1'b1 || s_if.out_data !== 32'h100 + 32'(wrap_addr[c-2]) || s_if.out_last !== (c == 6)) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_word[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             c - 2, s_if.out_valid, s_if.out_data, s_if.out_last, 32'h100 + 32'(wrap_addr[c-2]), (c == 6));
                end
            end
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_done: got %b expected 1", done); end
    endtask

    task automatic test_backpressure;
        int  guard;
        int  got;
        int  cyc;
        bit  rdy;
        base_addr = 5'd0;
        len = 5'd8;
        s_if.out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (s_if.out_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (guard >= 20) begin tests_failed++; $display("[TB] FAIL bp_first_valid: got timeout expected valid"); end
        repeat (6) @(negedge clk);
        tests_run++;
        if (raddr !== 5'd3) begin tests_failed++; $display("[TB] FAIL bp_stall_raddr: got %0d expected 3", raddr); end
        tests_run++;
        if (s_if.out_valid !== 1'b1 || s_if.out_data !== 32'h100) begin
            tests_failed++;
            $display("[TB] FAIL bp_stall_head: got v=%b d=%h expected v=1 d=00000100", s_if.out_valid, s_if.out_data);
        end
        got = 0;
        cyc = 0;
        rdy = 1'b1;
        while (got < 8 && cyc < 200) begin
            s_if.out_ready = rdy;
            if (s_if.out_valid === 1'b1 && rdy) begin
                tests_run++;
                if (s_if.out_data !== 32'h100 + 32'(got) || s_if.out_last !== (got == 7)) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_word[%0d]: got d=%h l=%b expected d=%h l=%b",
                             got, s_if.out_data, s_if.out_last, 32'h100 + 32'(got), (got == 7));
                end
                got++;
            end
            rdy = !rdy;
            cyc++;
            @(negedge clk);
        end
        s_if.out_ready = 1'b1;
        tests_run++;
        if (got != 8) begin tests_failed++; $display("[TB] FAIL bp_count: got %0d expected 8", got); end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || s_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_done: got done=%b busy=%b valid=%b expected 1 0 0", done, busy, s_if.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_and_ignored;
        int got;
        int cyc;
        bit extra;
        s_if.out_ready = 1'b1;
        base_addr = 5'd0;
        len = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (done !== 1'b1 || s_if.out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_done: got done=%b valid=%b busy=%b expected 1 0 0", done, s_if.out_valid, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || s_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_after: got done=%b valid=%b expected 0 0", done, s_if.out_valid);
        end
        base_addr = 5'd5;
        len = 5'd2;
        start = 1'b1;
        @(negedge clk);
        base_addr = 5'd9;
        len = 5'd6;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (s_if.out_valid === 1'b1) begin
                tests_run++;
                if (got >= 2 || s_if.out_data !== 32'h105 + 32'(got) || s_if.out_last !== (got == 1)) begin
                    tests_failed++;
                    $display("[TB] FAIL ign_word[%0d]: got d=%h l=%b expected d=%h l=%b",
                             got, s_if.out_data, s_if.out_last, 32'h105 + 32'(got), (got == 1));
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (got != 2 || done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ign_count: got words=%0d done=%b expected words=2 done=1", got, done);
        end
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (s_if.out_valid !== 1'b0 || busy !== 1'b0) extra = 1'b1;
        end
        tests_run++;
        if (extra !== 1'b0) begin tests_failed++; $display("[TB] FAIL ign_idle: got activity=%b expected 0", extra); end
    endtask

    task automatic test_reset_mid;
        int  got;
        int  cyc;
        bit  saw_done;
        base_addr = 5'd0;
        len = 5'd10;
        s_if.out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (s_if.out_valid === 1'b1) begin
                tests_run++;
                if (s_if.out_data !== 32'h100 + 32'(got)) begin
                    tests_failed++;
                    $display("[TB] FAIL rmid_word[%0d]: got %h expected %h", got, s_if.out_data, 32'h100 + 32'(got));
                end
                got++;
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (s_if.out_valid !== 1'b0 || s_if.out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || raddr !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL rmid_async: got valid=%b last=%b busy=%b done=%b raddr=%0d expected all 0",
                     s_if.out_valid, s_if.out_last, busy, done, raddr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || s_if.out_valid !== 1'b0) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_no_done: got activity=%b expected 0", saw_done); end
        base_addr = 5'd0;
        len = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (s_if.out_valid !== 1'b1 || s_if.out_data !== 32'h100 + 32'(i) || s_if.out_last !== (i == 1)) begin
                tests_failed++;
                $display("[TB] FAIL rmid_restart[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, s_if.out_valid, s_if.out_data, s_if.out_last, 32'h100 + 32'(i), (i == 1));
            end
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmid_restart_done: got %b expected 1", done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_and_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
